rose_implication_monitor: RTL and testbench
===========================================

# rose_implication_monitor

Synthesizable run-time checker that implements in hardware the property "rising edge of `trig` implies `sig` is high `DELAY` cycles later" (`$rose(trig) |-> ##DELAY sig`). It sits downstream of the stimulus/DUT signals that the simulation-only concurrent assertions check. It tallies pass, fail and vacuous evaluations so that results remain observable on silicon/FPGA and in benches without assertion support. It also provides a sticky failure flag and a cycle timestamp of the first failure.

## Interface
Parameters:
- `DELAY`, default 0: consequent offset in cycles after the antecedent sample, legal range 0..15.
- `CNT_W`, default 16: width of the pass, fail and vacuous counters.
- `TS_W`, default 32: width of the cycle counter and the first-fail timestamp.

Ports:
- `clk`, input, 1: single clock. All sampling happens on its rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `en`, input, 1: 1 enables the launch of new evaluations.
- `clr`, input, 1: synchronous clear of results and pending attempts.
- `trig`, input, 1: antecedent signal.
- `sig`, input, 1: consequent signal.
- `pass_pulse`, output, 1: one-cycle pulse when an attempt passes.
- `fail_pulse`, output, 1: one-cycle pulse when an attempt fails.
- `pass_cnt`, output, CNT_W: saturating count of passes.
- `fail_cnt`, output, CNT_W: saturating count of fails.
- `vac_cnt`, output, CNT_W: saturating count of vacuous samples.
- `fail_seen`, output, 1: sticky flag, set on the first fail.
- `first_fail_cyc`, output, TS_W: `cyc_cnt` value captured at the first fail.
- `cyc_cnt`, output, TS_W: free-running cycle counter.

## Operation
- **Sampling.** `trig` and `sig` are sampled at each rising `clk` edge, using the values settled before the edge (preponed semantics).
- **Rise detection.** Register `trig_q` holds the previous `trig` sample and resets to 0. `rose = trig & ~trig_q`. Consequently, `trig` sampled high at the first edge after reset counts as a rise.
- **Launch.** An attempt is launched when `en=1` and `rose=1` at a sample. A sample with `en=1` and `rose=0` is vacuous and increments `vac_cnt`. A sample with `en=0` launches nothing and counts nothing.
- **Pending attempts.** Attempts are held in a `DELAY+1`-stage shift register. Stage 0 is the launching sample. The attempt is evaluated against `sig` at the sample `DELAY` edges after launch.
- **Overlap.** Attempts overlap freely: every in-flight attempt is evaluated independently.
- **Effect of `en`.** Deasserting `en` does not cancel in-flight attempts; they still complete and are counted.
- **Evaluation result.**
  - Pass: if `sig=1`, `pass_pulse=1` and `pass_cnt++`.
  - Fail: if `sig=0`, `fail_pulse=1` and `fail_cnt++`.
  - On the first fail since reset or `clr`, `fail_seen` is set and `first_fail_cyc` captures `cyc_cnt` at the evaluating edge.
  - Later fails do not change `first_fail_cyc`.
- **Counters.** `pass_cnt`, `fail_cnt` and `vac_cnt` saturate at 2^CNT_W−1 and never wrap. `cyc_cnt` increments every edge and wraps modulo 2^TS_W. `cyc_cnt` is unaffected by `clr`.
- **Clear.** `clr=1` at an edge zeroes the following: all three counters, `fail_seen`, `first_fail_cyc`, the pending shift register, and both pulses. `clr` wins over a result or vacuous increment at the same edge. The `trig_q` update is still performed.
- **Reset.** Asserting `rst_n=0` immediately zeroes every output and all internal state (`trig_q`, pending register, `cyc_cnt`). Reset mid-attempt drops the attempt silently; no pulse or count is produced after release.

## Timing
- **Reset values.** Every output is 0.
- **`DELAY=0` latency.** The launching edge is also the evaluating edge. The pulse and counter update are visible in the cycle after that edge, i.e. registered outputs with one-cycle latency.
- **General latency.** A result appears `DELAY+1` cycles after the antecedent sample.
- **Pulse behaviour.**
  - `pass_pulse` and `fail_pulse` are mutually exclusive within any cycle, because at most one attempt is evaluated per edge.
  - Both are high for exactly one cycle per result.
  - Back-to-back results give back-to-back pulses.
- **Rise rate.** A rise can occur at most every 2 samples, so at most one attempt launches per edge.
- **`cyc_cnt` numbering.** `cyc_cnt` reads 0 in the cycle following reset release. It reads N after N edges.

## Test plan
- `DELAY=0`, `en=1`: `trig` 0→1 at sample 3 with `sig=1`. Expect `pass_pulse` high for one cycle after edge 3, `pass_cnt=1`, `fail_cnt=0`, and `vac_cnt` incremented on every other enabled sample.
- `DELAY=0`: rise with `sig=0` at `cyc_cnt=5`, then again at `cyc_cnt=9`. Expect `fail_cnt=2`, `fail_seen=1` after the first fail, and `first_fail_cyc=5` unchanged by the second fail.
- `DELAY=2`: rises at samples 4 and 6, `sig=1` at sample 6 and `sig=0` at sample 8. Expect the overlapping attempts to resolve independently: pass after edge 6, fail after edge 8, `pass_cnt=1`, `fail_cnt=1`.
- `CNT_W=4`: 20 consecutive passing attempts. Expect `pass_cnt` stuck at 15, no wrap.
- `clr` asserted at the same edge as a failing evaluation. Expect no `fail_pulse`, all counters 0, `fail_seen=0`, and `cyc_cnt` still incrementing.
- `DELAY=3`: launch at sample 2, `rst_n` low at sample 3 and released at sample 5, `sig=0` throughout. Expect outputs at 0 immediately on reset assertion, and no result pulse or count for the dropped attempt.

Source files
------------

// File: rtl/rose_implication_monitor_if.sv
// Bundle for the rose-implication monitor: sampled stimulus in, result pulses, counters and timestamps out.
interface rose_implication_monitor_if #(
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
);
    logic             en;
    logic             clr;
    logic             trig;
    logic             sig;
    logic             pass_pulse;
    logic             fail_pulse;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic [CNT_W-1:0] vac_cnt;
    logic             fail_seen;
    logic [TS_W-1:0]  first_fail_cyc;
    logic [TS_W-1:0]  cyc_cnt;

    modport master (
        output en, clr, trig, sig,
        input  pass_pulse, fail_pulse, pass_cnt, fail_cnt, vac_cnt,
               fail_seen, first_fail_cyc, cyc_cnt
    );

    modport slave (
        input  en, clr, trig, sig,
        output pass_pulse, fail_pulse, pass_cnt, fail_cnt, vac_cnt,
               fail_seen, first_fail_cyc, cyc_cnt
    );
endinterface

// File: rtl/rose_implication_monitor.sv
// Hardware checker for $rose(trig) |-> ##DELAY sig with saturating pass/fail/vacuous
// tallies, a sticky fail flag and a first-fail cycle timestamp.
module rose_implication_monitor #(
    parameter int DELAY = 0,
    parameter int CNT_W = 16,
    parameter int TS_W  = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    rose_implication_monitor_if.slave   mon_if
);

    logic             trig_q;
    logic             pass_pulse_q, pass_pulse_d;
    logic             fail_pulse_q, fail_pulse_d;
    logic [CNT_W-1:0] pass_cnt_q, pass_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q, fail_cnt_d;
    logic [CNT_W-1:0] vac_cnt_q, vac_cnt_d;
    logic             fail_seen_q, fail_seen_d;
    logic [TS_W-1:0]  first_fail_cyc_q, first_fail_cyc_d;
    logic [TS_W-1:0]  cyc_cnt_q;

    logic             rose;
    logic             launch;
    logic             due;
    logic [DELAY:0]   stage_w;

    assign rose       = mon_if.trig & ~trig_q;
    assign launch     = mon_if.en & rose;
    assign stage_w[0] = launch;
    assign due        = stage_w[DELAY];

    // Stage k of stage_w is the attempt launched k edges ago; only the delayed stages are stored.
    generate
        if (DELAY > 0) begin : g_pend
            logic [DELAY-1:0] pend_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_q <= '0;
                end else if (mon_if.clr) begin
                    pend_q <= '0;
                end else begin
                    pend_q <= stage_w[DELAY-1:0];
                end
            end

            assign stage_w[DELAY:1] = pend_q;
        end
    endgenerate

    always_comb begin
        pass_pulse_d     = 1'b0;
        fail_pulse_d     = 1'b0;
        pass_cnt_d       = pass_cnt_q;
        fail_cnt_d       = fail_cnt_q;
        vac_cnt_d        = vac_cnt_q;
        fail_seen_d      = fail_seen_q;
        first_fail_cyc_d = first_fail_cyc_q;

        if (mon_if.clr) begin
            pass_cnt_d       = '0;
            fail_cnt_d       = '0;
            vac_cnt_d        = '0;
            fail_seen_d      = 1'b0;
            first_fail_cyc_d = '0;
        end else begin
            if (mon_if.en && !rose && vac_cnt_q != '1) begin
                vac_cnt_d = vac_cnt_q + CNT_W'(1);
            end
            if (due) begin
                if (mon_if.sig) begin
                    pass_pulse_d = 1'b1;
                    if (pass_cnt_q != '1) begin
                        pass_cnt_d = pass_cnt_q + CNT_W'(1);
                    end
                end else begin
                    fail_pulse_d = 1'b1;
                    if (fail_cnt_q != '1) begin
                        fail_cnt_d = fail_cnt_q + CNT_W'(1);
                    end
                    // Timestamp is the counter value visible at the evaluating edge.
                    if (!fail_seen_q) begin
                        fail_seen_d      = 1'b1;
                        first_fail_cyc_d = cyc_cnt_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q           <= 1'b0;
            pass_pulse_q     <= 1'b0;
            fail_pulse_q     <= 1'b0;
            pass_cnt_q       <= '0;
            fail_cnt_q       <= '0;
            vac_cnt_q        <= '0;
            fail_seen_q      <= 1'b0;
            first_fail_cyc_q <= '0;
            cyc_cnt_q        <= '0;
        end else begin
            trig_q           <= mon_if.trig;
            pass_pulse_q     <= pass_pulse_d;
            fail_pulse_q     <= fail_pulse_d;
            pass_cnt_q       <= pass_cnt_d;
            fail_cnt_q       <= fail_cnt_d;
            vac_cnt_q        <= vac_cnt_d;
            fail_seen_q      <= fail_seen_d;
            first_fail_cyc_q <= first_fail_cyc_d;
            cyc_cnt_q        <= cyc_cnt_q + TS_W'(1);
        end
    end

    assign mon_if.pass_pulse     = pass_pulse_q;
    assign mon_if.fail_pulse     = fail_pulse_q;
    assign mon_if.pass_cnt       = pass_cnt_q;
    assign mon_if.fail_cnt       = fail_cnt_q;
    assign mon_if.vac_cnt        = vac_cnt_q;
    assign mon_if.fail_seen      = fail_seen_q;
    assign mon_if.first_fail_cyc = first_fail_cyc_q;
    assign mon_if.cyc_cnt        = cyc_cnt_q;

endmodule

// File: tb/tb_rose_implication_monitor.sv
// Directed bench for rose_implication_monitor across DELAY=0/2/3 and a 4-bit counter build.
module tb_rose_implication_monitor;

    logic clk = 1'b0;
    logic rst_n_a = 1'b0, rst_n_b = 1'b0, rst_n_c = 1'b0, rst_n_d = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    rose_implication_monitor_if #(.CNT_W(16), .TS_W(32)) ifa ();
    rose_implication_monitor_if #(.CNT_W(16), .TS_W(32)) ifb ();
    rose_implication_monitor_if #(.CNT_W(4),  .TS_W(32)) ifc ();
    rose_implication_monitor_if #(.CNT_W(16), .TS_W(32)) ifd ();

    rose_implication_monitor #(.DELAY(0), .CNT_W(16), .TS_W(32)) u_a (.clk(clk), .rst_n(rst_n_a), .mon_if(ifa));
    rose_implication_monitor #(.DELAY(2), .CNT_W(16), .TS_W(32)) u_b (.clk(clk), .rst_n(rst_n_b), .mon_if(ifb));
    rose_implication_monitor #(.DELAY(0), .CNT_W(4),  .TS_W(32)) u_c (.clk(clk), .rst_n(rst_n_c), .mon_if(ifc));
    rose_implication_monitor #(.DELAY(3), .CNT_W(16), .TS_W(32)) u_d (.clk(clk), .rst_n(rst_n_d), .mon_if(ifd));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int saw_pulse;

    initial begin
        ifa.en = 1'b0; ifa.clr = 1'b0; ifa.trig = 1'b0; ifa.sig = 1'b0;
        ifb.en = 1'b0; ifb.clr = 1'b0; ifb.trig = 1'b0; ifb.sig = 1'b0;
        ifc.en = 1'b0; ifc.clr = 1'b0; ifc.trig = 1'b0; ifc.sig = 1'b0;
        ifd.en = 1'b0; ifd.clr = 1'b0; ifd.trig = 1'b0; ifd.sig = 1'b0;

        // Reset state
        step(2);
        check("rst_pass_cnt", ifa.pass_cnt, 0);
        check("rst_cyc_cnt",  ifa.cyc_cnt, 0);
        check("rst_fail_seen", ifa.fail_seen, 0);

        // DELAY=0 single pass; every enabled non-rise sample is vacuous
        ifa.en = 1'b1; ifa.sig = 1'b1;
        rst_n_a = 1'b1;
        check("t1_cyc0", ifa.cyc_cnt, 0);
        step(2);
        check("t1_vac_pre", ifa.vac_cnt, 2);
        ifa.trig = 1'b1;
        step();
        check("t1_pass_pulse", ifa.pass_pulse, 1);
        check("t1_fail_pulse", ifa.fail_pulse, 0);
        check("t1_pass_cnt", ifa.pass_cnt, 1);
        check("t1_vac_rise", ifa.vac_cnt, 2);
        ifa.trig = 1'b0;
        step();
        check("t1_pulse_drop", ifa.pass_pulse, 0);
        check("t1_vac_post", ifa.vac_cnt, 3);
        check("t1_fail_cnt", ifa.fail_cnt, 0);
        check("t1_cyc4", ifa.cyc_cnt, 4);

        // DELAY=0 two fails; timestamp holds the first
        rst_n_a = 1'b0; ifa.sig = 1'b0;
        #1;
        rst_n_a = 1'b1;
        step(5);
        ifa.trig = 1'b1;
        step();
        check("t2_fail_pulse1", ifa.fail_pulse, 1);
        check("t2_fail_seen", ifa.fail_seen, 1);
        check("t2_first_cyc1", ifa.first_fail_cyc, 5);
        ifa.trig = 1'b0;
        step(3);
        ifa.trig = 1'b1;
        step();
        check("t2_fail_pulse2", ifa.fail_pulse, 1);
        check("t2_fail_cnt", ifa.fail_cnt, 2);
        check("t2_first_cyc2", ifa.first_fail_cyc, 5);
        check("t2_vac", ifa.vac_cnt, 8);
        check("t2_pass_cnt", ifa.pass_cnt, 0);

        // clr at the same edge as a failing evaluation
        ifa.trig = 1'b0;
        step();
        check("t3_pre_fail_cnt", ifa.fail_cnt, 2);
        ifa.trig = 1'b1; ifa.clr = 1'b1;
        step();
        check("t3_no_fail_pulse", ifa.fail_pulse, 0);
        check("t3_fail_cnt", ifa.fail_cnt, 0);
        check("t3_vac_cnt", ifa.vac_cnt, 0);
        check("t3_fail_seen", ifa.fail_seen, 0);
        check("t3_first_cyc", ifa.first_fail_cyc, 0);
        check("t3_cyc", ifa.cyc_cnt, 12);
        ifa.trig = 1'b0; ifa.clr = 1'b0;
        step();
        check("t3_vac_after", ifa.vac_cnt, 1);
        check("t3_cyc_after", ifa.cyc_cnt, 13);

        // DELAY=2 overlapping attempts; en drop does not cancel in-flight work
        ifb.en = 1'b1;
        rst_n_b = 1'b1;
        step(3);
        ifb.trig = 1'b1;
        step();
        check("t4_no_early", ifb.pass_pulse | ifb.fail_pulse, 0);
        ifb.trig = 1'b0;
        step();
        ifb.trig = 1'b1; ifb.sig = 1'b1;
        step();
        check("t4_pass_pulse", ifb.pass_pulse, 1);
        check("t4_pass_cnt", ifb.pass_cnt, 1);
        check("t4_vac6", ifb.vac_cnt, 4);
        ifb.trig = 1'b0; ifb.sig = 1'b0; ifb.en = 1'b0;
        step();
        check("t4_gap", {ifb.pass_pulse, ifb.fail_pulse}, 0);
        step();
        check("t4_fail_pulse", ifb.fail_pulse, 1);
        check("t4_fail_cnt", ifb.fail_cnt, 1);
        check("t4_pass_cnt8", ifb.pass_cnt, 1);
        check("t4_first_cyc", ifb.first_fail_cyc, 7);
        check("t4_vac8", ifb.vac_cnt, 4);

        // CNT_W=4 saturation over 20 passes
        ifc.en = 1'b1; ifc.sig = 1'b1;
        rst_n_c = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ifc.trig = 1'b1;
            step();
            if (i == 14) check("t5_pass15", ifc.pass_cnt, 15);
            ifc.trig = 1'b0;
            step();
        end
        check("t5_pass_sat", ifc.pass_cnt, 15);
        check("t5_vac_sat", ifc.vac_cnt, 15);
        check("t5_fail", ifc.fail_cnt, 0);
        ifc.trig = 1'b1;
        step();
        check("t5_pulse_at_sat", ifc.pass_pulse, 1);
        check("t5_pass_still", ifc.pass_cnt, 15);

        // DELAY=3 attempt dropped by reset
        ifd.en = 1'b1;
        rst_n_d = 1'b1;
        step();
        ifd.trig = 1'b1;
        step();
        check("t6_vac_pre", ifd.vac_cnt, 1);
        rst_n_d = 1'b0;
        #1;
        check("t6_rst_vac", ifd.vac_cnt, 0);
        check("t6_rst_cyc", ifd.cyc_cnt, 0);
        ifd.trig = 1'b0;
        step(2);
        rst_n_d = 1'b1;
        saw_pulse = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ifd.pass_pulse || ifd.fail_pulse) saw_pulse++;
        end
        check("t6_no_pulse", saw_pulse, 0);
        check("t6_fail_cnt", ifd.fail_cnt, 0);
        check("t6_fail_seen", ifd.fail_seen, 0);
        check("t6_vac", ifd.vac_cnt, 6);
        check("t6_cyc", ifd.cyc_cnt, 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
